// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the FSM state encoding, default geometry, the derived index width
// and the wait-state counter sizing.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int DEPTH_DEF   = 256;
  localparam int IDX_W_DEF   = $clog2(DEPTH_DEF);

  // Wait states are limited to 0..15, so a 4-bit counter always suffices.
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage for the data-memory responder.
// DEPTH x DATA_W array with a synchronous write port and a registered,
// enable-gated read port whose register is the responder's load-data output.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (read register only)
//   i_we     write enable
//   i_waddr  write word index
//   i_wdata  write data
//   i_re     read enable; captures the addressed word into o_rdata
//   i_raddr  read word index
//   o_rdata  registered read data, held while i_re is low
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the storage array is deliberately left out of reset; resetting a
  // RAM would force it into flops and is not wanted - contents survive rst.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEMORY stage's memread/memwrite interface.
// Accepts one word access at a time, inserts LATENCY wait states, then
// commits the write or returns the read word with a one-cycle done pulse.
// Misaligned or simultaneous read+write requests run the full latency and
// complete with err=1 and no side effects.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any pending access
//   memread    read request
//   memwrite   write request
//   addr       byte address; only bits [clog2(DEPTH)+1:0] are used
//   wdata      store data
//   read_data  load data, valid with done and held afterwards
//   done       one-cycle completion pulse
//   stall      hold request / freeze pipeline while high
//   err        qualifies done: access rejected
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = 2          // 0..LATENCY_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] read_data,
  output logic              done,
  output logic              stall,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd;
  logic              r_wr;
  logic              r_bad;

  logic              w_req;
  logic              w_in_idle;
  logic              w_accept;
  logic              w_enter_resp;
  logic              w_bad_now;
  logic [IDX_W-1:0]  w_op_idx;
  logic [DATA_W-1:0] w_op_wdata;
  logic              w_op_rd;
  logic              w_op_wr;
  logic              w_op_bad;
  logic              w_we;
  logic              w_re;
  logic              w_unused_addr;

  assign w_req     = memread | memwrite;
  assign w_in_idle = (r_state == IDLE);
  assign w_accept  = w_in_idle & w_req;
  assign w_bad_now = (addr[1:0] != 2'b00) | (memread & memwrite);

  // Upper address bits alias onto the same words.
  assign w_unused_addr = ^addr[31:IDX_W+2];

  // With LATENCY==0 the RESP entry edge is also the accept edge, so the
  // commit has to use the live request; otherwise it uses the latched copy.
  assign w_op_idx   = w_in_idle ? addr[IDX_W+1:2] : r_idx;
  assign w_op_wdata = w_in_idle ? wdata           : r_wdata;
  assign w_op_rd    = w_in_idle ? memread         : r_rd;
  assign w_op_wr    = w_in_idle ? memwrite        : r_wr;
  assign w_op_bad   = w_in_idle ? w_bad_now       : r_bad;

  assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP);
  // Gating with rst keeps an access that completes on a reset edge from
  // committing.
  assign w_we = w_enter_resp & ~rst & w_op_wr & ~w_op_bad;
  assign w_re = w_enter_resp & ~rst & w_op_rd & ~w_op_bad;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first guarantees every path drives
  // w_next_state, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next_state = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (r_cnt == '0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs. stall looks only at the request strobes and the state.
  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    case (r_state)
      IDLE:    stall = w_req;
      WAIT:    stall = 1'b1;
      RESP: begin
        done = 1'b1;
        err  = r_bad;
      end
      default: ;
    endcase
  end

  // Wait counter and request latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_bad   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= CNT_INIT;
      r_idx   <= addr[IDX_W+1:2];
      r_wdata <= wdata;
      r_rd    <= memread;
      r_wr    <= memwrite;
      r_bad   <= w_bad_now;
    end else if ((r_state == WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_op_idx),
    .i_wdata (w_op_wdata),
    .i_re    (w_re),
    .i_raddr (w_op_idx),
    .o_rdata (read_data)
  );

endmodule
